lane_rr_arbiter: RTL and testbench
==================================

// Module: lane_rr_arbiter
// PURPOSE
//  - Round-robin arbiter that grants one of 7 requesting aggregation lanes.
//  - Emits a registered 3-bit select code (0 = no grant, k = lane k-1) that drives the 3-to-8 lane-select decoder directly downstream.
//  - Holds each grant until the lane releases it, drops its request, or exceeds a hold timeout.
// PARAMETERS
//  NUM_LANES  7   lanes arbitrated; fixed by the 3-bit code, legal range 1..7
//  HOLD_MAX   16  max cycles a grant is held before forced release; >=1, <=255
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          asynchronous active-low reset
//  req         in   NUM_LANES  level request per lane; bit i = lane i
//  release_i   in   1          1-cycle pulse from granted lane: transaction done
//  gnt_code    out  3          registered select code to decoder; 0 idle, i+1 = lane i
//  gnt_valid   out  1          registered; 1 when gnt_code != 0
//  timeout_p   out  1          registered 1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - gnt_code=0, gnt_valid=0, timeout_p=0.
//    - State IDLE; rr pointer ptr=0; hold counter cnt=0.
//  - FSM states: IDLE, GRANT.
//  - IDLE:
//    - If |req, select the first lane i with req[i]=1, searching ptr, ptr+1, ... mod NUM_LANES.
//    - Next edge: gnt_code=i+1, gnt_valid=1, cnt=0, state GRANT.
//    - If req==0: remain IDLE with gnt_code=0.
//  - Latency: req sampled at edge N gives gnt_code valid after edge N (one register stage). No combinational path req->gnt_code.
//  - GRANT (lane g held):
//    - cnt increments each cycle, saturating at 255.
//    - Exit condition: release_i=1, OR req[g]=0, OR cnt==HOLD_MAX-1.
//    - On exit at edge: gnt_code=0, gnt_valid=0, ptr=(g+1) mod NUM_LANES, state IDLE.
//    - Exit always inserts a mandatory 1-cycle code-0 bubble, so the decoder never switches lanes back-to-back.
//  - Forced release: timeout_p=1 for exactly the cycle after the exit edge, only when the cnt condition alone caused the exit.
//  - Simultaneous events:
//    - release_i together with timeout: release wins, timeout_p=0.
//    - release_i in IDLE: ignored.
//    - Requests from other lanes during GRANT: ignored until IDLE.
//  - Fairness: after lane g is served, g has lowest priority. With all lanes requesting, grants rotate 0,1,...,6,0.
//  - ptr wrap: after lane NUM_LANES-1 is served, ptr=0.
//  - Reset mid-GRANT: outputs go to 0 immediately (asynchronously); ptr returns to 0.
//  - req bits at index >= NUM_LANES do not exist; gnt_code never exceeds NUM_LANES.
// TESTING
//  1. Reset, then req=7'b0000100 -> one edge later gnt_code=3, gnt_valid=1; pulse release_i -> next edge gnt_code=0.
//  2. req=7'h7F held, release_i pulsed each grant -> gnt_code sequence 1,0,2,0,...,7,0,1 (rotation plus bubbles, wrap to 1).
//  3. HOLD_MAX=4, req=7'b0000001 held, no release -> gnt_code=1 for 4 cycles, then 0 with timeout_p=1 for one cycle, then regrant 1.
//  4. In GRANT lane 5 (code 6), drop req[5] -> next edge gnt_code=0, timeout_p=0; ptr=6, so with req=7'h61 the next code is 7.
//  5. release_i and cnt==HOLD_MAX-1 on the same cycle -> gnt_code=0, timeout_p stays 0.
//  6. Assert rst_n=0 mid-GRANT between edges -> gnt_code=0 and gnt_valid=0 without a clock edge; after release with req=7'h7F the first code is 1.

Source files
------------

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter for up to 7 aggregation lanes; emits a registered 3-bit
// lane-select code (0 = idle, k = lane k-1) with a hold timeout and exit bubble.
module lane_rr_arbiter #(
  parameter int NUM_LANES = 7,
  parameter int HOLD_MAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 release_i,
  output logic [2:0]           gnt_code,
  output logic                 gnt_valid,
  output logic                 timeout_p
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gnt_code_q, gnt_code_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_p_q, timeout_p_d;

  // Padded copy so the rotating search can index with a full 3-bit value.
  logic [7:0] req_ext;
  assign req_ext = 8'(req);

  // One-hot of the lane currently held, derived from the registered code.
  logic [NUM_LANES-1:0] gnt_onehot;
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_onehot
    assign gnt_onehot[gi] = (gnt_code_q == 3'(gi + 1));
  end

  logic req_g;
  assign req_g = |(req & gnt_onehot);

  logic hold_expired;
  assign hold_expired = (cnt_q == 8'(HOLD_MAX - 1));

  logic [2:0] g_idx;
  logic [2:0] ptr_after_g;
  assign g_idx       = gnt_code_q - 3'd1;
  assign ptr_after_g = (g_idx == 3'(NUM_LANES - 1)) ? 3'd0 : g_idx + 3'd1;

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_LANES.
  logic       found;
  logic [2:0] sel_lane;
  logic [3:0] cand;
  always_comb begin
    found    = 1'b0;
    sel_lane = 3'd0;
    cand     = 4'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NUM_LANES)) begin
        cand = cand - 4'(NUM_LANES);
      end
      if (!found && req_ext[cand[2:0]]) begin
        found    = 1'b1;
        sel_lane = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_code_d  = gnt_code_q;
    timeout_p_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_code_d = 3'd0;
        if (found) begin
          gnt_code_d = sel_lane + 3'd1;
          cnt_d      = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_i || !req_g || hold_expired) begin
          // Exiting always yields a code-0 cycle before any new grant.
          gnt_code_d  = 3'd0;
          ptr_d       = ptr_after_g;
          state_d     = IDLE;
          timeout_p_d = hold_expired && !release_i && req_g;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_code_d = 3'd0;
      end
    endcase
    gnt_valid_d = (gnt_code_d != 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'd0;
      gnt_code_q  <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_p_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_code_q  <= gnt_code_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_p_q <= timeout_p_d;
    end
  end

  assign gnt_code  = gnt_code_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout_p = timeout_p_q;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Scoreboard bench for lane_rr_arbiter: each scenario queues the expected code
// and timeout pulse with its stimulus and compares once the edge has passed.
module tb_lane_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [6:0] req;
  logic       release_i;
  logic [2:0] gnt_code;
  logic       gnt_valid;
  logic       timeout_p;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] r;
    logic       rel;
    logic [2:0] code;
    logic       tmo;
  } step_t;

  step_t sb[$];

  lane_rr_arbiter #(
    .NUM_LANES(7),
    .HOLD_MAX (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .release_i(release_i),
    .gnt_code (gnt_code),
    .gnt_valid(gnt_valid),
    .timeout_p(timeout_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t s(input logic [6:0] r, input logic rel,
                              input logic [2:0] code, input logic tmo);
    step_t t;
    t.r    = r;
    t.rel  = rel;
    t.code = code;
    t.tmo  = tmo;
    return t;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 7'd0;
    release_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step_t e;
    rst_n     = 1'b0;
    req       = 7'h7F;
    release_i = 1'b0;
    #3;
    checks++;
    if (gnt_code !== 3'd0 || gnt_valid !== 1'b0 || timeout_p !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: code/valid/tmo got %0d/%0b/%0b expected 0/0/0",
               gnt_code, gnt_valid, timeout_p);
    end
    @(posedge clk); #1;
    checks++;
    if (gnt_code !== 3'd0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: code/valid got %0d/%0b expected 0/0", gnt_code, gnt_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 7'd0;
    sb.push_back(s(7'd0, 1'b0, 3'd0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
      errors++;
      $display("FAIL reset_idle: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
               gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
    end
    $display("reset: code=%0d valid=%0b tmo=%0b", gnt_code, gnt_valid, timeout_p);
  endtask

  task automatic test_single_grant();
    step_t st[$];
    step_t e;
    do_reset();
    st.push_back(s(7'b0000000, 1'b1, 3'd0, 1'b0));  // release while idle is ignored
    st.push_back(s(7'b0000100, 1'b0, 3'd3, 1'b0));
    st.push_back(s(7'b0000101, 1'b0, 3'd3, 1'b0));  // other lane ignored during grant
    st.push_back(s(7'b0000101, 1'b1, 3'd0, 1'b0));
    st.push_back(s(7'b0000000, 1'b0, 3'd0, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL single step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("single step %0d: req=%b rel=%0b code=%0d tmo=%0b", i, e.r, e.rel, gnt_code, timeout_p);
    end
  endtask

  task automatic test_rotation();
    step_t st[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      st.push_back(s(7'h7F, 1'b0, 3'(k + 1), 1'b0));
      st.push_back(s(7'h7F, 1'b1, 3'd0, 1'b0));
    end
    st.push_back(s(7'h7F, 1'b0, 3'd1, 1'b0));  // wrap back to lane 0
    st.push_back(s(7'h00, 1'b0, 3'd0, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL rotation step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("rotation step %0d: rel=%0b code=%0d", i, e.rel, gnt_code);
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 4; k++) st.push_back(s(7'b0000001, 1'b0, 3'd1, 1'b0));
    st.push_back(s(7'b0000001, 1'b0, 3'd0, 1'b1));  // forced release
    st.push_back(s(7'b0000001, 1'b0, 3'd1, 1'b0));  // regrant, pulse gone
    st.push_back(s(7'b0000001, 1'b1, 3'd0, 1'b0));
    st.push_back(s(7'b0000000, 1'b0, 3'd0, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL timeout step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("timeout step %0d: code=%0d tmo=%0b", i, gnt_code, timeout_p);
    end
  endtask

  task automatic test_req_drop();
    step_t st[$];
    step_t e;
    do_reset();
    st.push_back(s(7'b0100000, 1'b0, 3'd6, 1'b0));
    st.push_back(s(7'b0000000, 1'b0, 3'd0, 1'b0));  // drop req[5], ptr -> 6
    st.push_back(s(7'h61,      1'b0, 3'd7, 1'b0));
    st.push_back(s(7'h61,      1'b1, 3'd0, 1'b0));  // ptr wraps to 0
    st.push_back(s(7'h61,      1'b0, 3'd1, 1'b0));
    st.push_back(s(7'h00,      1'b0, 3'd0, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL req_drop step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("req_drop step %0d: req=%b code=%0d tmo=%0b", i, e.r, gnt_code, timeout_p);
    end
  endtask

  task automatic test_release_vs_timeout();
    step_t st[$];
    step_t e;
    do_reset();
    for (int k = 0; k < 4; k++) st.push_back(s(7'b0000001, 1'b0, 3'd1, 1'b0));
    st.push_back(s(7'b0000001, 1'b1, 3'd0, 1'b0));  // release wins over timeout
    st.push_back(s(7'b0000000, 1'b0, 3'd0, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL rel_vs_tmo step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("rel_vs_tmo step %0d: rel=%0b code=%0d tmo=%0b", i, e.rel, gnt_code, timeout_p);
    end
  endtask

  task automatic test_reset_mid_grant();
    step_t st[$];
    step_t e;
    do_reset();
    st.push_back(s(7'h7F, 1'b0, 3'd1, 1'b0));
    st.push_back(s(7'h7F, 1'b1, 3'd0, 1'b0));
    st.push_back(s(7'h7F, 1'b0, 3'd2, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL mid_rst pre step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("mid_rst pre step %0d: code=%0d", i, gnt_code);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_code !== 3'd0 || gnt_valid !== 1'b0 || timeout_p !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst async: code/valid/tmo got %0d/%0b/%0b expected 0/0/0",
               gnt_code, gnt_valid, timeout_p);
    end
    $display("mid_rst async: code=%0d valid=%0b", gnt_code, gnt_valid);
    @(negedge clk);
    rst_n = 1'b1;
    st.delete();
    st.push_back(s(7'h7F, 1'b0, 3'd1, 1'b0));  // ptr back at 0
    st.push_back(s(7'h7F, 1'b1, 3'd0, 1'b0));
    st.push_back(s(7'h7F, 1'b0, 3'd2, 1'b0));
    foreach (st[i]) begin
      req = st[i].r; release_i = st[i].rel; sb.push_back(st[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gnt_code !== e.code || gnt_valid !== (e.code != 3'd0) || timeout_p !== e.tmo) begin
        errors++;
        $display("FAIL mid_rst post step %0d: code/valid/tmo got %0d/%0b/%0b expected %0d/%0b/%0b",
                 i, gnt_code, gnt_valid, timeout_p, e.code, e.code != 3'd0, e.tmo);
      end
      $display("mid_rst post step %0d: code=%0d", i, gnt_code);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_timeout();
    test_req_drop();
    test_release_vs_timeout();
    test_reset_mid_grant();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
